// File: rtl/ej32_dc_seq.sv
// ============================================================================
// ej32_dc_seq : eJ32 opcode register and table-driven per-instruction phase sequencer
// rev 1.0
// ============================================================================
`default_nettype none

module ej32_dc_seq #(
  parameter int         PH_W   = 3,
  parameter int         NBSY   = 2,
  parameter logic [7:0] RST_OP = 8'h00
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      data,
  input  logic            fetch_vld,
  input  logic [NBSY-1:0] busy,
  output logic [7:0]      code,
  output logic [PH_W-1:0] phase,
  output logic            au_en,
  output logic            br_en,
  output logic            ls_en,
  output logic            p_inc,
  output logic            last,
  output logic            op_err
);

  localparam logic [7:0] c_OP_ERR = 8'hff;
  localparam int         c_CW     = (PH_W > 3) ? PH_W : 3;

  typedef enum logic [1:0] {
    CL_SINGLE = 2'd0,
    CL_STEP   = 2'd1,
    CL_WAIT   = 2'd2,
    CL_STALL  = 2'd3
  } cls_t;

  typedef struct packed {
    logic       legal;
    cls_t       cls;
    logic [2:0] n;
    logic [3:0] bsel;
    logic       au;
    logic       br;
    logic       ls;
  } op_info_t;

  // n is the index of the final phase; STALL always uses phases 0..1
  function automatic op_info_t op_info(input logic [7:0] op);
    op_info_t r;
    r = '{legal: 1'b1, cls: CL_SINGLE, n: 3'd0, bsel: 4'd0,
          au: 1'b0, br: 1'b0, ls: 1'b0};
    case (op) inside
      8'h00: ;
      [8'h02:8'h08], 8'h57, 8'h59, 8'h5f, 8'h60, 8'h64, 8'h74,
      8'h78, 8'h7a, 8'h7c, 8'h7e, 8'h80, 8'h82:
        r.au = 1'b1;
      8'h10: begin r.cls = CL_STEP; r.n = 3'd1; r.au = 1'b1; end
      8'h11: begin r.cls = CL_STEP; r.n = 3'd2; r.au = 1'b1; end
      8'h12: begin r.cls = CL_STEP; r.n = 3'd4; r.au = 1'b1; end
      8'h15: begin r.au = 1'b1; r.br = 1'b1; end
      8'h2e: begin r.cls = CL_WAIT; r.n = 3'd5; r.ls = 1'b1; end
      8'h33: begin r.cls = CL_WAIT; r.n = 3'd2; r.ls = 1'b1; end
      8'h35: begin r.cls = CL_WAIT; r.n = 3'd3; r.ls = 1'b1; end
      8'h4f: begin r.cls = CL_WAIT; r.n = 3'd5; r.au = 1'b1; r.ls = 1'b1; end
      8'h54: begin r.cls = CL_WAIT; r.n = 3'd2; r.au = 1'b1; r.ls = 1'b1; end
      8'h56: begin r.cls = CL_WAIT; r.n = 3'd3; r.au = 1'b1; r.ls = 1'b1; end
      8'h58: begin r.cls = CL_WAIT; r.n = 3'd1; r.au = 1'b1; end
      8'h5a: begin r.cls = CL_WAIT; r.n = 3'd2; r.au = 1'b1; end
      8'h5c: begin r.cls = CL_WAIT; r.n = 3'd3; r.au = 1'b1; end
      8'h68: begin
        r.au = 1'b1;
        if (NBSY > 1) begin r.cls = CL_STALL; r.n = 3'd1; r.bsel = 4'd1; end
      end
      8'h6c, 8'h70: begin r.cls = CL_STALL; r.n = 3'd1; r.au = 1'b1; end
      8'h84, 8'ha8: begin
        r.cls = CL_WAIT; r.n = 3'd2; r.au = 1'b1; r.br = 1'b1; r.ls = 1'b1;
      end
      [8'h99:8'ha7]: begin r.cls = CL_STEP; r.n = 3'd2; r.br = 1'b1; end
      8'hd3: begin r.cls = CL_WAIT; r.n = 3'd2; r.ls = 1'b1; end
      8'hd4: begin r.cls = CL_WAIT; r.n = 3'd1; r.ls = 1'b1; end
      default: r.legal = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic op_legal(input logic [7:0] op);
    op_info_t r;
    r = op_info(op);
    return r.legal;
  endfunction

  op_info_t          w_inf;
  logic [c_CW-1:0]   w_ph;
  logic [c_CW-1:0]   w_n;
  logic              w_bsy;
  logic              w_act;
  logic              w_pinc;
  logic              w_last;
  logic [7:0]        w_nxt_code;
  logic [PH_W-1:0]   w_nxt_phase;

  assign w_inf = op_info(code);
  assign w_ph  = c_CW'(phase);
  assign w_n   = c_CW'(w_inf.n);

  always_comb begin
    w_bsy = 1'b0;
    for (int i = 0; i < NBSY; i++) begin
      if (w_inf.bsel == 4'(i)) w_bsy = busy[i];
    end
  end

  always_comb begin
    w_act       = 1'b0;
    w_pinc      = 1'b0;
    w_last      = 1'b0;
    w_nxt_code  = code;
    w_nxt_phase = phase;
    if (w_inf.cls == CL_STALL && w_ph == c_CW'(0)) begin
      w_act       = 1'b1;
      w_nxt_phase = phase + 1'b1;
    end else if (w_inf.cls == CL_STALL && w_ph == c_CW'(1) && w_bsy) begin
      w_act = 1'b1;
    end else if (!fetch_vld) begin
      w_act = 1'b0;
    end else if (w_ph >= w_n) begin
      // ">" only after corruption: recover by loading the next opcode
      w_act       = 1'b1;
      w_pinc      = 1'b1;
      w_last      = 1'b1;
      w_nxt_phase = '0;
      w_nxt_code  = op_legal(data) ? data : c_OP_ERR;
    end else begin
      w_act       = 1'b1;
      w_pinc      = (w_inf.cls == CL_STEP);
      w_nxt_phase = phase + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      code  <= RST_OP;
      phase <= '0;
    end else begin
      code  <= w_nxt_code;
      phase <= w_nxt_phase;
    end
  end

  assign au_en  = rst & w_act & w_inf.au;
  assign br_en  = rst & w_act & w_inf.br;
  assign ls_en  = rst & w_act & w_inf.ls;
  assign p_inc  = rst & w_pinc;
  assign last   = rst & w_last;
  assign op_err = rst & w_act & ~w_inf.legal;

endmodule

`default_nettype wire
